// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    localparam int FETCH_ADDR_W     = 32;
    localparam int FETCH_DATA_W     = 32;
    localparam int FETCH_DEPTH      = 2;
    localparam int FETCH_IMEM_WORDS = 256;

    // addi x0, x0, 0 -- delivered in place of an out-of-range fetch
    localparam logic [FETCH_DATA_W-1:0] FETCH_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_DATA_W-1:0] instr;
        logic                    fault;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Bundle of the PC, instruction-memory and decode handshakes around fetch.
interface fetch_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] pc_in;
    logic              pc_valid;
    logic              pc_ready;
    logic              flush;
    logic              imem_rd_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_fault;

    // fetch unit side
    modport slave (
        input  pc_in, pc_valid, flush, imem_rdata, instr_ready,
        output pc_ready, imem_rd_en, imem_addr, instr_valid, instr, instr_pc, instr_fault
    );

    // environment side: PC source, memory and decode
    modport master (
        output pc_in, pc_valid, flush, imem_rdata, instr_ready,
        input  pc_ready, imem_rd_en, imem_addr, instr_valid, instr, instr_pc, instr_fault
    );
endinterface

// File: rtl/fetch_fifo.sv
// Small FIFO of fetched entries; clear empties it in one cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push,
    input  fetch_entry_t   push_data,
    input  logic           pop,
    input  logic           clear,
    output fetch_entry_t   head,
    output logic [CW-1:0]  count
);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_eff, pop_eff;

    // next-state: pointers wrap naturally because DEPTH is a power of two
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pop_eff  = pop && (count_q != '0);
        push_eff = push && ((count_q < CW'(DEPTH)) || pop_eff);
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_eff) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop_eff) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push_eff) - CW'(pop_eff);
        end
    end

    // state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: issues PC reads to synchronous imem and buffers {pc, instr, fault}
// for decode, granting new PCs only while a buffer slot is guaranteed.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W     = FETCH_ADDR_W,
    parameter int DATA_W     = FETCH_DATA_W,
    parameter int DEPTH      = FETCH_DEPTH,
    parameter int IMEM_WORDS = FETCH_IMEM_WORDS
) (
    input  logic    clk,
    input  logic    rst,
    fetch_if.slave  bus
);

    localparam int CW = $clog2(DEPTH + 1);

    // one outstanding fetch (read or faulted PC) waiting to be captured
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] tag_pc_q, tag_pc_d;
    logic              tag_fault_q, tag_fault_d;

    logic [CW-1:0]     count;
    logic [CW:0]       used;
    fetch_entry_t      head, push_entry;
    logic              push, pop, accept, in_range, ready, valid;

    // credit check, acceptance, memory strobe and capture path
    always_comb begin
        in_range = bus.pc_in < ADDR_W'(IMEM_WORDS);
        // a faulted PC also consumes a slot next cycle, so it counts as outstanding
        used     = {1'b0, count} + {{CW{1'b0}}, pend_q};
        ready    = rst && !bus.flush && (used < (CW+1)'(DEPTH));
        accept   = bus.pc_valid && ready;

        pend_d      = accept;
        tag_pc_d    = accept ? bus.pc_in : tag_pc_q;
        tag_fault_d = accept ? !in_range : tag_fault_q;

        // flush squashes whatever is being captured this cycle
        push             = pend_q && !bus.flush;
        push_entry.pc    = tag_pc_q;
        push_entry.instr = tag_fault_q ? FETCH_NOP : bus.imem_rdata;
        push_entry.fault = tag_fault_q;

        valid = (count != '0);
        pop   = valid && bus.instr_ready;
    end

    // outstanding-fetch tag register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q      <= 1'b0;
            tag_pc_q    <= '0;
            tag_fault_q <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            tag_pc_q    <= tag_pc_d;
            tag_fault_q <= tag_fault_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .clear     (bus.flush),
        .head      (head),
        .count     (count)
    );

    assign bus.pc_ready    = ready;
    assign bus.imem_rd_en  = accept && in_range;
    assign bus.imem_addr   = (accept && in_range) ? bus.pc_in : '0;
    assign bus.instr_valid = valid;
    assign bus.instr       = valid ? head.instr : '0;
    assign bus.instr_pc    = valid ? head.pc    : '0;
    assign bus.instr_fault = valid && head.fault;

endmodule
